// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end. Generates sequential fetch addresses, issues
//   them to a multi-cycle instruction memory over a req/ready handshake (one
//   request outstanding at most), and buffers returned words with their PCs
//   in a DEPTH-entry FIFO feeding the IF/ID register. A flush from ID
//   redirects fetch; a request already on the bus when the flush arrives is
//   allowed to complete and its data is dropped (DISCARD state).
//
//   Optional build macro:
//     FETCH_BYPASS_EN - when the FIFO is empty, a word arriving from memory is
//                       presented on the inst_* outputs in the same cycle and
//                       is consumed without being written if inst_ready_i=1.
//
//   Ports:
//     clk            rising-edge clock
//     rst            asynchronous reset, active low
//     flush_i        redirect fetch (branch taken in ID)
//     flush_target_i redirect address, low two bits ignored
//     mem_req_o      memory request valid
//     mem_addr_o     memory request address
//     mem_ready_i    memory accepts request; mem_data_i valid same cycle
//     mem_data_i     fetched instruction word
//     inst_valid_o   head entry valid
//     inst_o         head instruction (0 when empty)
//     inst_pc_o      head PC (0 when empty)
//     inst_ready_i   downstream pops the head
//     count_o        FIFO occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          flush_target_i,
  output logic                       mem_req_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_ready_i,
  input  logic [INST_W-1:0]          mem_data_i,
  output logic                       inst_valid_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_pc_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;        // next address to fetch
  logic [ADDR_W-1:0]   stale_q, stale_d;  // address still on the bus in DISCARD
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  entry_t [DEPTH-1:0]  mem_q;

  // ---------------------------------------------------------------------------
  // Handshake / FIFO control
  // ---------------------------------------------------------------------------
  logic              xfer;
  logic              fifo_pop;
  logic              push;
  logic              byp;       // same-cycle forward of memory data
  logic              byp_take;  // forwarded word consumed downstream
  logic [CW-1:0]     cnt_pop;   // count after this cycle's pop
  logic [CW-1:0]     cnt_post;  // count after pop and push
  logic [ADDR_W-1:0] target;
  entry_t            head;

  assign mem_req_o = (state_q != S_IDLE);
  assign xfer      = mem_req_o & mem_ready_i;
  assign fifo_pop  = (cnt_q != '0) & inst_ready_i;

`ifdef FETCH_BYPASS_EN
  assign byp      = (cnt_q == '0) & (state_q == S_REQ) & mem_ready_i & ~flush_i;
  assign byp_take = byp & inst_ready_i;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  // Only REQ-state transfers carry live data; a flush kills the word.
  assign push     = (state_q == S_REQ) & xfer & ~flush_i & ~byp_take;
  assign cnt_pop  = cnt_q - CW'(fifo_pop);
  assign cnt_post = cnt_pop + CW'(push);

  // Word-align by masking rather than slicing so every target bit is used.
  assign target   = flush_target_i & ~ADDR_W'(3);

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    if (flush_i) begin
      pc_d = target;
      unique case (state_q)
        S_IDLE:    state_d = S_REQ;
        S_REQ: begin
          if (xfer) begin
            state_d = S_REQ;
          end else begin
            // Request can't be withdrawn; keep its address on the bus.
            state_d = S_DISCARD;
            stale_d = pc_q;
          end
        end
        S_DISCARD: state_d = xfer ? S_REQ : S_DISCARD;
        default:   state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cnt_pop < DEPTH_C) state_d = S_REQ;
        end
        S_REQ: begin
          if (xfer) begin
            pc_d    = pc_q + ADDR_W'(4);
            state_d = (cnt_post < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end
        S_DISCARD: begin
          if (xfer) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers / occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push)     wr_d = wr_q + PW'(1);
      if (fifo_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_post;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q].pc   <= pc_q;
      mem_q[wr_q].inst <= mem_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head       = mem_q[rd_q];
  assign mem_addr_o = (state_q == S_DISCARD) ? stale_q : pc_q;
  assign count_o    = cnt_q;

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = '0;
    inst_pc_o    = '0;
    if (cnt_q != '0) begin
      inst_valid_o = 1'b1;
      inst_o       = head.inst;
      inst_pc_o    = head.pc;
    end else if (byp) begin
      inst_valid_o = 1'b1;
      inst_o       = mem_data_i;
      inst_pc_o    = pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=4, RESET_PC=0). The memory model
//   returns addr ^ 32'hC0DE0000 unless an override word is forced.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_i = 1'b0;
  logic [AW-1:0] flush_target_i = '0;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ready_i = 1'b0;
  logic [IW-1:0] mem_data_i;
  logic          inst_valid_o;
  logic [IW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_ready_i = 1'b0;
  logic [2:0]    count_o;

  logic          ovr_en = 1'b0;
  logic [IW-1:0] ovr_data = '0;

  int n_chk = 0;
  int n_err = 0;

  assign mem_data_i = ovr_en ? ovr_data : (mem_addr_o ^ 32'hC0DE0000);

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .flush_target_i (flush_target_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ready_i    (mem_ready_i),
    .mem_data_i     (mem_data_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_ready_i   (inst_ready_i),
    .count_o        (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lands 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one rising edge; returns with reset released, just
  // after an edge, so the following edge is the first functional one.
  task automatic do_reset(input logic mr, input logic ir);
    tick();
    rst          = 1'b0;
    flush_i      = 1'b0;
    ovr_en       = 1'b0;
    mem_ready_i  = mr;
    inst_ready_i = ir;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- 1: reset values, streaming fetch ----------------
    rst = 1'b0; mem_ready_i = 1'b1; inst_ready_i = 1'b1;
    #2;
    chk("rst_req",   mem_req_o,    1'b0);
    chk("rst_addr",  mem_addr_o,   32'h0);
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst",  inst_o,       32'h0);
    chk("rst_pc",    inst_pc_o,    32'h0);
    chk("rst_cnt",   count_o,      3'd0);
    do_reset(1'b1, 1'b1);
    tick(); #1;
    chk("t1_req0",  mem_req_o,  1'b1);
    chk("t1_addr0", mem_addr_o, 32'h0);
    chk("t1_cnt0",  count_o,    3'd0);
    tick(); #1;
    chk("t1_addr4", mem_addr_o,   32'h4);
    chk("t1_val",   inst_valid_o, 1'b1);
    chk("t1_pc0",   inst_pc_o,    32'h0);
    chk("t1_inst0", inst_o,       32'hC0DE0000);
    chk("t1_cnt1",  count_o,      3'd1);
    tick(); #1;
    chk("t1_addr8", mem_addr_o, 32'h8);
    chk("t1_pc4",   inst_pc_o,  32'h4);
    tick(); #1;
    chk("t1_pc8",   inst_pc_o,  32'h8);
    chk("t1_cnt",   count_o,    3'd1);

    // ---------------- 2: fill to DEPTH, single pop ----------------
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("t2_full",  count_o,    3'd4);
    chk("t2_noreq", mem_req_o,  1'b0);
    chk("t2_addr",  mem_addr_o, 32'h10);
    tick(); inst_ready_i = 1'b1; #1;
    chk("t2_hold",  count_o,    3'd4);
    chk("t2_idle",  mem_req_o,  1'b0);
    tick(); inst_ready_i = 1'b0; #1;
    chk("t2_cnt3",  count_o,    3'd3);
    chk("t2_req",   mem_req_o,  1'b1);
    chk("t2_raddr", mem_addr_o, 32'h10);
    chk("t2_head",  inst_pc_o,  32'h4);
    tick(); #1;
    chk("t2_refull", count_o,   3'd4);
    chk("t2_stop",  mem_req_o,  1'b0);
    chk("t2_hpc",   inst_pc_o,  32'h4);
    chk("t2_hins",  inst_o,     32'hC0DE0004);

    // ---------------- 3: wait states hold the address ----------------
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    mem_ready_i = 1'b0; #1;
    chk("t3_a0", mem_addr_o, 32'h10);
    tick(); #1;
    chk("t3_a1", mem_addr_o, 32'h10);
    chk("t3_r1", mem_req_o,  1'b1);
    tick(); #1;
    chk("t3_a2", mem_addr_o, 32'h10);
    tick(); mem_ready_i = 1'b1; #1;
    chk("t3_a3", mem_addr_o, 32'h10);
    chk("t3_c3", count_o,    3'd0);
    tick(); inst_ready_i = 1'b0; mem_ready_i = 1'b0; #1;
    chk("t3_cnt", count_o,   3'd1);
    chk("t3_pc",  inst_pc_o, 32'h10);
    chk("t3_nxt", mem_addr_o, 32'h14);
    tick(); #1;
    chk("t3_one", count_o,   3'd1);

    // ---------------- 4: flush while request waits -> DISCARD ----------------
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    mem_ready_i = 1'b0; #1;
    chk("t4_a20", mem_addr_o, 32'h20);
    tick(); flush_i = 1'b1; flush_target_i = 32'h103; #1;
    chk("t4_wait", mem_addr_o, 32'h20);
    tick(); flush_i = 1'b0; #1;
    chk("t4_dreq", mem_req_o,  1'b1);
    chk("t4_dadr", mem_addr_o, 32'h20);
    chk("t4_dcnt", count_o,    3'd0);
    tick(); mem_ready_i = 1'b1; #1;
    chk("t4_dadr2", mem_addr_o, 32'h20);
    tick(); #1;
    chk("t4_tgt",  mem_addr_o,   32'h100);
    chk("t4_drop", count_o,      3'd0);
    chk("t4_nval", inst_valid_o, 1'b0);
    tick(); #1;
    chk("t4_cnt",  count_o,   3'd1);
    chk("t4_pc",   inst_pc_o, 32'h100);
    chk("t4_inst", inst_o,    32'hC0DE0100);

    // ---------------- 5: flush with transfer and pop same cycle ----------------
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    flush_i = 1'b1; flush_target_i = 32'h200; #1;
    chk("t5_pre", count_o,    3'd1);
    chk("t5_adr", mem_addr_o, 32'h8);
    tick(); flush_i = 1'b0; #1;
    chk("t5_cnt0", count_o,      3'd0);
    chk("t5_nval", inst_valid_o, 1'b0);
    chk("t5_tgt",  mem_addr_o,   32'h200);
    chk("t5_req",  mem_req_o,    1'b1);
    tick(); #1;
    chk("t5_cnt1", count_o,   3'd1);
    chk("t5_pc",   inst_pc_o, 32'h200);

    // ---------------- 6: empty-FIFO transfer (bypass or not) ----------------
    do_reset(1'b0, 1'b1);
    flush_i = 1'b1; flush_target_i = 32'h40;
    tick();
    flush_i = 1'b0; mem_ready_i = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEADBEEF; #1;
    chk("t6_req",  mem_req_o,  1'b1);
    chk("t6_addr", mem_addr_o, 32'h40);
`ifdef FETCH_BYPASS_EN
    chk("t6_bval", inst_valid_o, 1'b1);
    chk("t6_binst", inst_o,      32'hDEADBEEF);
    chk("t6_bpc",  inst_pc_o,    32'h40);
    tick(); mem_ready_i = 1'b0; ovr_en = 1'b0; #1;
    chk("t6_bcnt", count_o, 3'd0);
`else
    chk("t6_nval",  inst_valid_o, 1'b0);
    chk("t6_ninst", inst_o,       32'h0);
    tick(); mem_ready_i = 1'b0; ovr_en = 1'b0; #1;
    chk("t6_cnt",  count_o,   3'd1);
    chk("t6_inst", inst_o,    32'hDEADBEEF);
    chk("t6_pc",   inst_pc_o, 32'h40);
`endif

    // ---------------- mid-operation reset ----------------
    rst = 1'b0; #1;
    chk("mr_req", mem_req_o,    1'b0);
    chk("mr_cnt", count_o,      3'd0);
    chk("mr_val", inst_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that generates instruction addresses and fetches from a multi-cycle instruction memory through a request/ready handshake. Fetched words are buffered with their PCs in a DEPTH-entry FIFO that feeds the IF/ID register. Branch redirects arrive from ID as a flush. Successor to the single-cycle pc_reg/ROM fetch path: configurable width, configurable depth, wait-state tolerant, in-flight-safe redirect.

Parameters:
ADDR_W, 32, instruction address width.
INST_W, 32, instruction word width.
DEPTH, 4, FIFO entries; power of two, >=2.
RESET_PC, 0, first fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low (0 = reset).
flush_i  in  1  redirect fetch; from ID branch flag.
flush_target_i  in  ADDR_W  redirect address; bits [1:0] forced to 0.
mem_req_o  out  1  memory request valid.
mem_addr_o  out  ADDR_W  request address.
mem_ready_i  in  1  memory accepts the request; mem_data_i is valid in the same cycle.
mem_data_i  in  INST_W  fetched instruction.
inst_valid_o  out  1  head entry valid.
inst_o  out  INST_W  head instruction; 0 when empty.
inst_pc_o  out  ADDR_W  head PC; 0 when empty.
inst_ready_i  in  1  downstream pops the head (deasserted while the pipeline is stalled).
count_o  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch_pc=RESET_PC, rd/wr pointers=0, count=0.
- Reset outputs: mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, count_o=0.
- Mid-operation reset: everything is abandoned immediately; no response is consumed afterward.
- States: IDLE (no request), REQ (request to fetch_pc outstanding), DISCARD (stale request outstanding; its response is dropped).
  - mem_req_o=1 in REQ and DISCARD.
  - mem_addr_o=fetch_pc in REQ; the stale address in DISCARD.
  - mem_addr_o is stable while mem_req_o=1 and mem_ready_i=0.
- One outstanding request maximum. A transfer is mem_req_o and mem_ready_i both high on a clock edge.
- IDLE -> REQ when the FIFO will not be full next cycle (count minus pop < DEPTH). Otherwise stay in IDLE.
- REQ transfer, no flush:
  - Push {fetch_pc, mem_data_i}; fetch_pc += 4 (wraps modulo 2^ADDR_W).
  - Stay in REQ if the post-update count < DEPTH, else go to IDLE.
- Pop when inst_valid_o and inst_ready_i. Push and pop in the same cycle leave count unchanged.
- A push never occurs when full: issue is gated on space, and only one request is outstanding.
- Flush (highest priority):
  - FIFO cleared next cycle (count=0); any pop or push in the flush cycle is discarded.
  - fetch_pc <= {flush_target_i[ADDR_W-1:2], 2'b00}.
  - State transitions on flush:
    - IDLE -> REQ.
    - REQ with transfer that cycle -> REQ at target.
    - REQ without transfer -> DISCARD (old address held).
    - DISCARD with transfer -> REQ at target.
    - DISCARD without transfer -> DISCARD with target updated.
- DISCARD transfer, no flush: data dropped, go to REQ at the saved target.
- Latency with memory ready every cycle: the address is first on the bus 1 cycle after reset release. Its instruction is visible on inst_o 1 cycle after the transfer.
- Throughput: 1 instruction per cycle with zero wait states.
- inst_valid_o = (count != 0), derived from registered state.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when the FIFO is empty, state=REQ, a transfer occurs and flush_i=0:
  - inst_valid_o=1, inst_o=mem_data_i, inst_pc_o=fetch_pc in the same cycle.
  - If inst_ready_i=1 the word is consumed and not written; otherwise it is pushed normally.
- Undefined: there is no combinational path from memory to the outputs, and there is always 1 cycle of FIFO latency.

Test Plan:
1. Reset release, mem_ready_i tied to 1, inst_ready_i=1 -> mem_addr_o sequence 0x0, 0x4, 0x8. inst_pc_o=0x0 one cycle after the first transfer; 1 instruction per cycle.
2. inst_ready_i=0, DEPTH=4 -> exactly 4 pushes, count_o=4, mem_req_o=0. Raise inst_ready_i for 1 cycle -> one pop and one new request; no overflow.
3. mem_ready_i low for 3 cycles on addr 0x10 -> mem_addr_o holds 0x10 throughout. Single push on the 4th cycle.
4. flush_i with target 0x103 while REQ to 0x20 is waiting -> DISCARD, mem_addr_o stays 0x20 until ready. Data dropped, next request 0x100, FIFO empty after the flush.
5. Flush in the same cycle as a transfer and a pop -> neither the pushed word nor the pop takes effect. count_o=0 next cycle, next address = target.
6. FETCH_BYPASS_EN defined, empty FIFO, transfer of 0xDEADBEEF at 0x40 with inst_ready_i=1 -> inst_o=0xDEADBEEF and inst_pc_o=0x40 in the same cycle, count_o stays 0.
